// File: rtl/ahb_slave_regbank.sv
// AHB-Lite responder exposing a window of 32-bit registers with configurable wait states.
// Out-of-window accesses get a two-cycle ERROR response; BUSY/IDLE transfers are ignored.
module ahb_slave_regbank #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic [1:0]  Htrans,
   input  logic        Hreadyin,
   input  logic        Hwrite,
   input  logic [31:0] Haddr,
   input  logic [31:0] HWdata,
   output logic [31:0] HRdata,
   output logic        Hreadyout,
   output logic [1:0]  Hresp
);

   localparam int unsigned IDX_W     = $clog2(NUM_REGS);
   localparam logic [31:0] WIN_BYTES = 32'(4 * NUM_REGS);
   localparam logic [2:0]  CNT_INIT  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t             state, next_state;
   logic [31:0]        regs [NUM_REGS];
   logic [IDX_W-1:0]   idx_q, dec_idx, rd_idx;
   logic               write_q;
   logic [2:0]         cnt;
   logic [31:0]        off, rd_val;
   logic               in_win, accept, rd_load;

   always_comb begin
      off     = Haddr - BASE_ADDR;
      in_win  = off < WIN_BYTES;
      dec_idx = off[IDX_W+1:2];
      accept  = (state == S_IDLE || state == S_DATA || state == S_ERR2) && Hreadyin &&
                (Htrans == 2'b10 || Htrans == 2'b11);
   end

   always_comb begin
      next_state = state;
      rd_load    = 1'b0;
      rd_idx     = idx_q;
      case (state)
         S_WAIT: begin
            if (cnt == 3'd0) begin
               next_state = S_DATA;
               rd_load    = !write_q;
            end
         end
         S_ERR1: next_state = S_ERR2;
         default: begin
            next_state = S_IDLE;
            if (accept) begin
               if (!in_win) begin
                  next_state = S_ERR1;
               end else if (WAIT_STATES == 0) begin
                  next_state = S_DATA;
                  rd_load    = !Hwrite;
                  rd_idx     = dec_idx;
               end else begin
                  next_state = S_WAIT;
               end
            end
         end
      endcase
   end

   // A write leaving DATA commits on the same edge that loads a pipelined read; forward it.
   always_comb begin
      rd_val = regs[rd_idx];
      if (state == S_DATA && write_q && rd_idx == idx_q) rd_val = HWdata;
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state     <= S_IDLE;
         cnt       <= '0;
         idx_q     <= '0;
         write_q   <= 1'b0;
         Hreadyout <= 1'b1;
         Hresp     <= 2'b00;
         HRdata    <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         state     <= next_state;
         Hreadyout <= !(next_state == S_WAIT || next_state == S_ERR1);
         Hresp     <= (next_state == S_ERR1 || next_state == S_ERR2) ? 2'b01 : 2'b00;
         if (accept) begin
            idx_q   <= dec_idx;
            write_q <= Hwrite;
         end
         if (accept && in_win) cnt <= CNT_INIT;
         else if (state == S_WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
         if (state == S_DATA && write_q) regs[idx_q] <= HWdata;
         if (rd_load) HRdata <= rd_val;
      end
   end

endmodule

// File: tb/tb_ahb_slave_regbank.sv
// Randomized self-checking bench for ahb_slave_regbank: three instances with 1, 0 and 3 wait
// states, each driven by its own bus and compared against a transfer-level register model.
module tb_ahb_slave_regbank;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk;
   logic        rst_n     [3];
   logic [1:0]  htrans    [3];
   logic        hreadyin  [3];
   logic        hwrite    [3];
   logic [31:0] haddr     [3];
   logic [31:0] hwdata    [3];
   logic [31:0] hrdata    [3];
   logic        hreadyout [3];
   logic [1:0]  hresp     [3];

   int          n_tests = 0;
   int          n_fail  = 0;
   int          ws_of [3] = '{1, 0, 3};
   logic [31:0] mregs [3][8];
   logic [31:0] mrd   [3];

   bit          b_wr   [32];
   logic [31:0] b_addr [32];
   logic [31:0] b_data [32];
   int          b_n;

   ahb_slave_regbank #(.BASE_ADDR(BASE), .NUM_REGS(8), .WAIT_STATES(1)) u_ws1 (
      .Hclk(clk), .Hresetn(rst_n[0]), .Htrans(htrans[0]), .Hreadyin(hreadyin[0]),
      .Hwrite(hwrite[0]), .Haddr(haddr[0]), .HWdata(hwdata[0]), .HRdata(hrdata[0]),
      .Hreadyout(hreadyout[0]), .Hresp(hresp[0]));

   ahb_slave_regbank #(.BASE_ADDR(BASE), .NUM_REGS(8), .WAIT_STATES(0)) u_ws0 (
      .Hclk(clk), .Hresetn(rst_n[1]), .Htrans(htrans[1]), .Hreadyin(hreadyin[1]),
      .Hwrite(hwrite[1]), .Haddr(haddr[1]), .HWdata(hwdata[1]), .HRdata(hrdata[1]),
      .Hreadyout(hreadyout[1]), .Hresp(hresp[1]));

   ahb_slave_regbank #(.BASE_ADDR(BASE), .NUM_REGS(8), .WAIT_STATES(3)) u_ws3 (
      .Hclk(clk), .Hresetn(rst_n[2]), .Htrans(htrans[2]), .Hreadyin(hreadyin[2]),
      .Hwrite(hwrite[2]), .Haddr(haddr[2]), .HWdata(hwdata[2]), .HRdata(hrdata[2]),
      .Hreadyout(hreadyout[2]), .Hresp(hresp[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Window membership computed as a plain 33-bit range test.
   function automatic bit model_in_win(input logic [31:0] a);
      logic [32:0] a33, lo, hi;
      a33 = {1'b0, a};
      lo  = {1'b0, BASE};
      hi  = lo + 33'd32;
      return (a33 >= lo) && (a33 < hi);
   endfunction

   function automatic int model_idx(input logic [31:0] a);
      logic [31:0] d;
      d = a - BASE;
      return int'(d / 4);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input int k);
      check($sformatf("idle_rdy%0d", k), 32'(hreadyout[k]), 32'd1);
      check($sformatf("idle_resp%0d", k), 32'(hresp[k]), 32'd0);
      check($sformatf("idle_rd%0d", k), hrdata[k], mrd[k]);
   endtask

   task automatic model_reset(input int k);
      for (int i = 0; i < 8; i++) mregs[k][i] = '0;
      mrd[k] = '0;
   endtask

   // One non-pipelined transfer: address phase, then the whole data phase, then back to IDLE.
   task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
      bit inw;
      int idx;
      inw = model_in_win(addr);
      idx = model_idx(addr);
      htrans[k]   = 2'b10;
      hwrite[k]   = wr;
      haddr[k]    = addr;
      hreadyin[k] = 1'b1;
      step();
      htrans[k] = 2'b00;
      haddr[k]  = $urandom;
      hwrite[k] = 1'($urandom_range(0, 1));
      hwdata[k] = wd;
      if (inw) begin
         for (int i = 0; i < ws_of[k]; i++) begin
            check($sformatf("wait_rdy%0d", k), 32'(hreadyout[k]), 32'd0);
            check($sformatf("wait_resp%0d", k), 32'(hresp[k]), 32'd0);
            step();
         end
         check($sformatf("data_rdy%0d", k), 32'(hreadyout[k]), 32'd1);
         check($sformatf("data_resp%0d", k), 32'(hresp[k]), 32'd0);
         if (!wr) mrd[k] = mregs[k][idx];
         check($sformatf("data_rd%0d", k), hrdata[k], mrd[k]);
         step();
         if (wr) mregs[k][idx] = wd;
      end else begin
         check($sformatf("err1_rdy%0d", k), 32'(hreadyout[k]), 32'd0);
         check($sformatf("err1_resp%0d", k), 32'(hresp[k]), 32'd1);
         step();
         check($sformatf("err2_rdy%0d", k), 32'(hreadyout[k]), 32'd1);
         check($sformatf("err2_resp%0d", k), 32'(hresp[k]), 32'd1);
         check($sformatf("err2_rd%0d", k), hrdata[k], mrd[k]);
         step();
      end
      check_idle(k);
   endtask

   // A cycle that must never start a transfer: IDLE/BUSY, or NONSEQ/SEQ with Hreadyin low.
   task automatic idle_cycle(input int k);
      if ($urandom_range(0, 2) == 0) begin
         htrans[k]   = 2'($urandom_range(2, 3));
         hreadyin[k] = 1'b0;
      end else begin
         htrans[k]   = 2'($urandom_range(0, 1));
         hreadyin[k] = 1'b1;
      end
      hwrite[k] = 1'($urandom_range(0, 1));
      haddr[k]  = (k == 0) ? BASE + 32'($urandom_range(0, 31)) : $urandom;
      hwdata[k] = $urandom;
      step();
      check_idle(k);
      htrans[k]   = 2'b00;
      hreadyin[k] = 1'b1;
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)       return BASE + 32'($urandom_range(0, 31));
      else if (r == 7) return BASE - 32'($urandom_range(1, 16));
      else if (r == 8) return BASE + 32'd32 + 32'($urandom_range(0, 64));
      else             return $urandom;
   endfunction

   // Back-to-back pipelined transfers on the zero-wait instance; model applies them in order.
   task automatic burst_ws0();
      for (int j = 0; j <= b_n; j++) begin
         if (j < b_n) begin
            htrans[1] = (j == 0) ? 2'b10 : 2'b11;
            hwrite[1] = b_wr[j];
            haddr[1]  = b_addr[j];
         end else begin
            htrans[1] = 2'b00;
            haddr[1]  = $urandom;
         end
         if (j > 0) hwdata[1] = b_data[j-1];
         hreadyin[1] = 1'b1;
         step();
         if (j > 0 && b_wr[j-1]) mregs[1][model_idx(b_addr[j-1])] = b_data[j-1];
         if (j < b_n) begin
            check("burst_rdy", 32'(hreadyout[1]), 32'd1);
            check("burst_resp", 32'(hresp[1]), 32'd0);
            if (!b_wr[j]) mrd[1] = mregs[1][model_idx(b_addr[j])];
            check("burst_rd", hrdata[1], mrd[1]);
         end
      end
      check_idle(1);
   endtask

   task automatic push(input bit wr, input logic [31:0] a, input logic [31:0] d);
      b_wr[b_n]   = wr;
      b_addr[b_n] = a;
      b_data[b_n] = d;
      b_n++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0; htrans[k] = 2'b00; hreadyin[k] = 1'b1; hwrite[k] = 1'b0;
         haddr[k] = '0; hwdata[k] = '0;
         model_reset(k);
      end
      repeat (2) step();
      for (int k = 0; k < 3; k++) check_idle(k);
      for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
      step();

      for (int i = 0; i < 8; i++) xfer(0, 1'b0, BASE + 32'(4 * i), '0);

      xfer(0, 1'b1, 32'h8000_0001, 32'h0000_0990);
      xfer(0, 1'b0, 32'h8000_0001, $urandom);
      check("t2_readback", hrdata[0], 32'h0000_0990);

      xfer(0, 1'b1, 32'h8000_0040, 32'hDEAD_BEEF);
      xfer(0, 1'b1, 32'h7FFF_FFFC, 32'hCAFE_F00D);
      xfer(0, 1'b0, 32'h7FFF_FFFC, '0);
      for (int i = 0; i < 8; i++) xfer(0, 1'b0, BASE + 32'(4 * i), '0);

      for (int k = 0; k < 3; k++) repeat (6) idle_cycle(k);

      b_n = 0;
      for (int i = 0; i < 4; i++) push(1'b1, BASE + 32'(4 * i), 32'(i + 1));
      push(1'b1, 32'h8000_0008, 32'h0000_00AA);
      push(1'b0, 32'h8000_0008, '0);
      for (int i = 0; i < 8; i++) push(1'b0, BASE + 32'(4 * i), '0);
      burst_ws0();
      check("t4_fwd_val", mregs[1][2], 32'h0000_00AA);

      for (int r = 0; r < 3; r++) begin
         b_n = 0;
         for (int i = 0; i < 20; i++)
            push(1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 31)), $urandom);
         burst_ws0();
      end

      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < 3; k++) begin
            xfer(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle(k);
         end
      end

      xfer(2, 1'b1, 32'h8000_0004, 32'h1234_5678);
      xfer(2, 1'b0, 32'h8000_0004, '0);
      htrans[2] = 2'b10; hwrite[2] = 1'b1; haddr[2] = 32'h8000_0004; hreadyin[2] = 1'b1;
      step();
      htrans[2] = 2'b00; hwdata[2] = 32'h5555_AAAA;
      check("t6_wait_rdy", 32'(hreadyout[2]), 32'd0);
      step();
      rst_n[2] = 1'b0;
      #1;
      model_reset(2);
      check("t6_rst_rdy", 32'(hreadyout[2]), 32'd1);
      check("t6_rst_resp", 32'(hresp[2]), 32'd0);
      check("t6_rst_rd", hrdata[2], 32'd0);
      step();
      rst_n[2] = 1'b1;
      step();
      xfer(2, 1'b0, 32'h8000_0004, '0);
      for (int i = 0; i < 8; i++) xfer(2, 1'b0, BASE + 32'(4 * i), '0);

      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 8; i++) xfer(k, 1'b0, BASE + 32'(4 * i), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
